// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-master round-robin Wishbone-classic arbiter in front of one memory slave.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   m0_* / m1_*                     master side: cyc, stb, we, sel[3:0], addr[31:0], data_out[31:0] in;
//                                   data_in[31:0], ack, err out
//   s_*                             slave side: cyc, stb, we, sel[3:0], addr[31:0], data_out[31:0] out;
//                                   data_in[31:0], ack in
// Build option: define WB_ARB_TIMEOUT_EN to add a no-ack watchdog of TIMEOUT_CYCLES cycles;
// without it m0_err/m1_err are tied low.
module wb_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data_out,
  output logic [31:0] m0_data_in,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data_out,
  output logic [31:0] m1_data_in,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_addr,
  output logic [31:0] s_data_out,
  input  logic [31:0] s_data_in,
  input  logic        s_ack
);
  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} state_t;
  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   own0, own1, busy, req0, req1, to_hit;
  assign own0 = state_q == BUSY_M0;
  assign own1 = state_q == BUSY_M1;
  assign busy = own0 | own1;
  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign to_hit = busy && cnt_q == CW'(TIMEOUT_CYCLES);
  // Zero while idle so every grant starts from a clean count; an ack or an abort also clears it.
  always_comb cnt_d = (!busy || s_ack || to_hit) ? '0 : cnt_q + CW'(s_stb);
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (state_q == IDLE) begin
      if (req0 && (!req1 || !prio_q)) begin
        state_d = BUSY_M0;
        prio_d  = 1'b1;
      end else if (req1) begin
        state_d = BUSY_M1;
        prio_d  = 1'b0;
      end
    end else if (to_hit || (own0 ? !m0_cyc : !m1_cyc)) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign s_cyc      = own0 ? m0_cyc      : own1 & m1_cyc;
  assign s_stb      = own0 ? m0_stb      : own1 & m1_stb;
  assign s_we       = own0 ? m0_we       : own1 & m1_we;
  assign s_sel      = own0 ? m0_sel      : own1 ? m1_sel      : '0;
  assign s_addr     = own0 ? m0_addr     : own1 ? m1_addr     : '0;
  assign s_data_out = own0 ? m0_data_out : own1 ? m1_data_out : '0;
  assign m0_data_in = own0 ? s_data_in : '0;
  assign m1_data_in = own1 ? s_data_in : '0;
  // An abort cycle reports err instead of ack even if the slave answers late.
  assign m0_ack     = own0 & s_ack & !to_hit;
  assign m1_ack     = own1 & s_ack & !to_hit;
  assign m0_err     = own0 & to_hit;
  assign m1_err     = own1 & to_hit;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed self-checking bench for wb_mem_arbiter.
module tb_wb_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [3:0]  m0_sel = '0;
  logic [31:0] m0_addr = '0, m0_data_out = '0, m0_data_in;
  logic        m0_ack, m0_err;
  logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [3:0]  m1_sel = '0;
  logic [31:0] m1_addr = '0, m1_data_out = '0, m1_data_in;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_data_out;
  logic [31:0] s_data_in = '0;
  logic        s_ack = 1'b0;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  wb_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_addr(m0_addr), .m0_data_out(m0_data_out), .m0_data_in(m0_data_in),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_addr(m1_addr), .m1_data_out(m1_data_out), .m1_data_in(m1_data_in),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_addr(s_addr), .s_data_out(s_data_out), .s_data_in(s_data_in), .s_ack(s_ack)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step;
    step;
    chk("reset_s_cyc", s_cyc, 0);
    chk("reset_m0_ack", m0_ack, 0);
    rst_n = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_sel = 4'hf; m0_addr = 32'h100;
    #1 chk("single_idle_before_grant", s_cyc, 0);
    step;
    chk("single_s_cyc", s_cyc, 1);
    chk("single_s_stb", s_stb, 1);
    chk("single_s_addr", s_addr, 32'h100);
    chk("single_s_sel", s_sel, 4'hf);
    chk("single_s_we", s_we, 0);
    s_ack = 1'b1; s_data_in = 32'hDEADBEEF;
    #1 chk("single_m0_ack", m0_ack, 1);
    chk("single_m0_data", m0_data_in, 32'hDEADBEEF);
    chk("single_m1_ack", m1_ack, 0);
    chk("single_m1_data", m1_data_in, 0);
    step;
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1 chk("single_drop_s_cyc", s_cyc, 0);
    step;
    chk("single_idle_data", m0_data_in, 0);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_sel = 4'h3; m1_addr = 32'h300;
    step;
    chk("rst_mid_s_cyc_before", s_cyc, 1);
    chk("rst_mid_s_addr_before", s_addr, 32'h300);
    s_ack = 1'b1; s_data_in = 32'hCAFEF00D;
    #1 chk("rst_mid_m1_ack_before", m1_ack, 1);
    rst_n = 1'b0;
    #1 chk("rst_mid_s_cyc", s_cyc, 0);
    chk("rst_mid_s_stb", s_stb, 0);
    chk("rst_mid_s_addr", s_addr, 0);
    chk("rst_mid_s_sel", s_sel, 0);
    chk("rst_mid_m1_ack", m1_ack, 0);
    chk("rst_mid_m1_data", m1_data_in, 0);
    chk("rst_mid_m1_err", m1_err, 0);
    step;
    rst_n = 1'b1; s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step;
    chk("post_reset_idle", s_cyc, 0);
    m0_addr = 32'h10; m1_addr = 32'h20;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fair%0d_s_cyc", i), s_cyc, 1);
      chk($sformatf("fair%0d_owner_addr", i), s_addr, (i % 2) ? 32'h20 : 32'h10);
      s_ack = 1'b1; s_data_in = 32'h1000 + i;
      #1 chk($sformatf("fair%0d_m0_ack", i), m0_ack, (i % 2) ? 0 : 1);
      chk($sformatf("fair%0d_m1_ack", i), m1_ack, (i % 2) ? 1 : 0);
      chk($sformatf("fair%0d_owner_data", i), (i % 2) ? m1_data_in : m0_data_in, 32'h1000 + i);
      step;
      s_ack = 1'b0;
      if (i % 2) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      else begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      #1 chk($sformatf("fair%0d_drop", i), s_cyc, 0);
      step;
      chk($sformatf("fair%0d_turnaround", i), s_cyc, 0);
      if (i < 5) begin
        if (i % 2) begin m1_cyc = 1'b1; m1_stb = 1'b1; end
        else begin m0_cyc = 1'b1; m0_stb = 1'b1; end
        step;
      end
    end
    m0_we = 1'b1; m0_addr = 32'h200; m0_data_out = 32'hA0;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("burst%0d_addr", k), s_addr, 32'h200 + 4 * k);
      chk($sformatf("burst%0d_we", k), s_we, 1);
      chk($sformatf("burst%0d_wdata", k), s_data_out, 32'hA0 + k);
      s_ack = 1'b1;
      #1 chk($sformatf("burst%0d_m0_ack", k), m0_ack, 1);
      chk($sformatf("burst%0d_m1_ack", k), m1_ack, 0);
      step;
      s_ack = 1'b0;
      if (k < 2) begin m0_addr = m0_addr + 4; m0_data_out = m0_data_out + 1; end
      else begin m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; end
    end
    #1 chk("burst_end_drop", s_cyc, 0);
    chk("burst_end_m1_ack", m1_ack, 0);
    step;
    chk("burst_turnaround", s_cyc, 0);
    step;
    chk("burst_m1_granted", s_cyc, 1);
    chk("burst_m1_addr", s_addr, 32'h20);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h40;
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("wd_stall%0d_err", i), m1_err, 0);
      chk($sformatf("wd_stall%0d_s_cyc", i), s_cyc, 1);
      step;
    end
    chk("wd_m1_err_pulse", m1_err, 1);
    chk("wd_m1_ack", m1_ack, 0);
    chk("wd_m0_err", m0_err, 0);
    step;
    chk("wd_abort_s_cyc", s_cyc, 0);
    chk("wd_abort_err_clear", m1_err, 0);
    step;
    chk("wd_m0_granted", s_cyc, 1);
    chk("wd_m0_addr", s_addr, 32'h40);
    chk("wd_m0_err_after", m0_err, 0);
`else
    for (int i = 0; i < 12; i++) begin
      #1 chk($sformatf("nowd%0d_m1_err", i), m1_err, 0);
      chk($sformatf("nowd%0d_s_cyc", i), s_cyc, 1);
      chk($sformatf("nowd%0d_s_addr", i), s_addr, 32'h20);
      step;
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
